// File: rtl/stopwatch_ctrl.sv
// Stopwatch button sequencer: turns the start/stop and lap/reset button levels
// into one-cycle {stop, reset, start} pulses, tracks run state and freezes the display on lap capture.
module stopwatch_ctrl #(
    parameter int unsigned LAP_HOLD_CYCLES = 200000000,
    parameter int unsigned HOLD_W          = 28,
    parameter int unsigned LAP_W           = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_ss,
    input  logic              btn_lr,
    input  logic [31:0]       count,
    output logic [2:0]        control,
    output logic [31:0]       display_value,
    output logic              lap_active,
    output logic              running,
    output logic [LAP_W-1:0]  lap_num
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_PAUSED = 2'd2;
    localparam logic [1:0] S_LAP    = 2'd3;

    localparam logic [2:0] CTRL_NONE  = 3'b000;
    localparam logic [2:0] CTRL_START = 3'b001;
    localparam logic [2:0] CTRL_RESET = 3'b010;
    localparam logic [2:0] CTRL_STOP  = 3'b100;

    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(LAP_HOLD_CYCLES - 1);

    logic [1:0]        r_state;
    logic [2:0]        r_control;
    logic [LAP_W-1:0]  r_lap_num;
    logic [31:0]       r_lap_latch;
    logic [HOLD_W-1:0] r_hold;
    logic              r_ss_prev;
    logic              r_lr_prev;

    logic              w_ss_ev;
    logic              w_lr_ev;
    logic [1:0]        w_state_nxt;
    logic [2:0]        w_control_nxt;
    logic [LAP_W-1:0]  w_lap_num_nxt;
    logic [LAP_W-1:0]  w_lap_num_inc;
    logic [31:0]       w_lap_latch_nxt;
    logic [HOLD_W-1:0] w_hold_nxt;

    // Rising-edge detect: a held button yields a single event
    assign w_ss_ev = btn_ss & ~r_ss_prev;
    assign w_lr_ev = btn_lr & ~r_lr_prev;

    assign w_lap_num_inc = (r_lap_num == {LAP_W{1'b1}}) ? r_lap_num
                                                        : r_lap_num + LAP_W'(1);

    // State register and all sequential state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_control   <= CTRL_RESET;
            r_lap_num   <= '0;
            r_lap_latch <= '0;
            r_hold      <= '0;
            r_ss_prev   <= 1'b0;
            r_lr_prev   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_control   <= w_control_nxt;
            r_lap_num   <= w_lap_num_nxt;
            r_lap_latch <= w_lap_latch_nxt;
            r_hold      <= w_hold_nxt;
            r_ss_prev   <= btn_ss;
            r_lr_prev   <= btn_lr;
        end
    end

    // Next-state and pulse decode; start/stop takes priority, a coincident lap/reset is dropped
    always_comb begin
        w_state_nxt     = r_state;
        w_control_nxt   = CTRL_NONE;
        w_lap_num_nxt   = r_lap_num;
        w_lap_latch_nxt = r_lap_latch;
        w_hold_nxt      = r_hold;

        case (r_state)
            S_IDLE: begin
                if (w_ss_ev) begin
                    w_control_nxt = CTRL_START;
                    w_state_nxt   = S_RUN;
                end else if (w_lr_ev) begin
                    w_control_nxt = CTRL_RESET;
                    w_lap_num_nxt = '0;
                end
            end
            S_RUN: begin
                if (w_ss_ev) begin
                    w_control_nxt = CTRL_STOP;
                    w_state_nxt   = S_PAUSED;
                end else if (w_lr_ev) begin
                    w_lap_latch_nxt = count;
                    w_hold_nxt      = HOLD_LOAD;
                    w_lap_num_nxt   = w_lap_num_inc;
                    w_state_nxt     = S_LAP;
                end
            end
            S_LAP: begin
                if (w_ss_ev) begin
                    w_control_nxt = CTRL_STOP;
                    w_hold_nxt    = '0;
                    w_state_nxt   = S_PAUSED;
                end else if (w_lr_ev) begin
                    w_lap_latch_nxt = count;
                    w_hold_nxt      = HOLD_LOAD;
                    w_lap_num_nxt   = w_lap_num_inc;
                end else if (r_hold == '0) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_hold_nxt = r_hold - HOLD_W'(1);
                end
            end
            S_PAUSED: begin
                if (w_ss_ev) begin
                    w_control_nxt = CTRL_START;
                    w_state_nxt   = S_RUN;
                end else if (w_lr_ev) begin
                    w_control_nxt = CTRL_RESET;
                    w_lap_num_nxt = '0;
                    w_state_nxt   = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign control       = r_control;
    assign lap_num       = r_lap_num;
    assign lap_active    = (r_state == S_LAP);
    assign running       = (r_state == S_RUN) || (r_state == S_LAP);
    assign display_value = (r_state == S_LAP) ? r_lap_latch : count;

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Button-driven sequencer for the stopwatch counter. Turns two debounced push-button levels into one-cycle {stop, reset, start} control pulses.
- Tracks the stopwatch run state and implements a lap-freeze display with automatic release. Also keeps a lap counter.
- Sits between the button debouncers and the stopwatch counter/display path. All logic is in the single system clock domain.

Parameters:
- LAP_HOLD_CYCLES, 200000000, cycles the display stays frozen after a lap capture (2 s at 100 MHz); must be >= 1.
- HOLD_W, 28, width of the lap hold timer; 2^HOLD_W must be > LAP_HOLD_CYCLES-1.
- LAP_W, 4, width of the lap number counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- btn_ss  in  1  start/stop button level, debounced, synchronous to clk.
- btn_lr  in  1  lap/reset button level, debounced, synchronous to clk.
- count  in  32  live stopwatch count.
- control  out  3  {stop, reset, start} to the stopwatch counter; registered, one-hot or zero.
- display_value  out  32  value for the display path.
- lap_active  out  1  high while the display is frozen (state LAP).
- running  out  1  high in RUN or LAP.
- lap_num  out  LAP_W  number of laps captured since the last reset pulse.

Behaviour:
- Clock and reset: one clock `clk`. `reset` is synchronous and active-high.
- Reset values:
  - While `reset` is high: state=IDLE, control=3'b010 (clears the counter), lap_num=0, lap_latch=0, hold timer=0, prev button regs=0.
  - The first edge with reset low drives control=3'b000 unless an event fires.
- Edge detection:
  - ss_ev = btn_ss & ~ss_prev; lr_ev = btn_lr & ~lr_prev.
  - Prev regs update every cycle.
  - A held button produces exactly one event.
- Control outputs:
  - All are single-cycle pulses, registered at the edge where the event is sampled. They are visible the following cycle.
  - control=3'b000 in every other cycle.
- FSM states: IDLE, RUN, PAUSED, LAP.
  - IDLE: ss_ev -> start pulse (3'b001), go to RUN. lr_ev -> reset pulse (3'b010), stay IDLE, lap_num<=0.
  - RUN: ss_ev -> stop pulse (3'b100), go to PAUSED. lr_ev -> lap_latch<=count, load hold timer with LAP_HOLD_CYCLES-1, lap_num++ (saturates at 2^LAP_W-1), go to LAP. No control pulse.
  - LAP:
    - ss_ev -> stop pulse, go to PAUSED.
    - lr_ev -> recapture lap_latch<=count, reload timer, lap_num++ (saturating), stay LAP.
    - Otherwise, if timer==0 go to RUN; else timer decrements by 1.
    - Without new events, LAP lasts exactly LAP_HOLD_CYCLES cycles.
  - PAUSED: ss_ev -> start pulse, go to RUN. lr_ev -> reset pulse, lap_num<=0, go to IDLE.
- Simultaneous ss_ev and lr_ev in the same cycle: ss_ev wins and lr_ev is discarded. This is a dropped event, not deferred.
- display_value is combinational: lap_latch when state==LAP, else count.
- running is combinational from state (RUN or LAP). lap_active is combinational from state (LAP).
- Reset mid-operation (any state, including LAP with the timer active): next state is IDLE, the hold timer is cleared, and the freeze is cancelled immediately.
- Timer width: must not wrap. It only loads and decrements from LAP_HOLD_CYCLES-1 to 0.

Test Plan:
- Setup for all scenarios: LAP_HOLD_CYCLES=4, count driven as a free-running ramp from the bench.
1. Reset for 2 cycles -> control=3'b010 both cycles, then 3'b000; state IDLE, lap_num=0, running=0.
2. IDLE, btn_ss rises and is held for 10 cycles -> exactly one control=3'b001 pulse the cycle after the rise; running=1; no further pulses while held.
3. RUN, btn_lr rises when count=100 -> display_value=100 for exactly 4 cycles, lap_active=1, lap_num=1, control stays 000. Then display_value follows count again and running stays 1.
4. LAP, second btn_lr rise at count=102 -> lap_latch=102, timer reloads (4 more frozen cycles), lap_num=2. A ss rise then gives control=3'b100, state PAUSED, lap_active=0.
5. PAUSED, btn_ss and btn_lr rise in the same cycle -> only 3'b001 is emitted, state RUN, lap_num unchanged. Then stop and an lr rise -> 3'b100, then 3'b010, lap_num=0, state IDLE.
6. Reset asserted on the 2nd cycle of LAP -> next cycle state IDLE, lap_active=0, control=3'b010, display_value=count.
